core_div_iter: RTL and testbench
================================

// Module: core_div_iter
// PURPOSE
//  Iterative radix-2 restoring divider feeding the core divide result-formatting stage.
//  - Captures RV64M/RV64M-W divide operands and takes operand magnitudes for signed ops.
//  - Runs one quotient bit per cycle.
//  - Presents unsigned quotient/remainder magnitudes, operand sign flags and op
//    control/isword, held stable for sign correction and W-mode sign extension downstream.
// PARAMETERS
//  XLEN  64  datapath width; word ops use XLEN/2
// PORTS
//  i_clk                       in   1     clock; all state updates on rising edge
//  i_rst                       in   1     synchronous active-high reset
//  i_div_iter_start            in   1     op request; accepted when high with o_div_iter_ready high
//  i_div_iter_flush            in   1     abort in-flight op (pipeline kill)
//  i_div_iter_control          in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0=unsigned)
//  i_div_iter_isword           in   1     1 = W-variant (operate on low XLEN/2 bits)
//  i_div_iter_srcA             in   XLEN  dividend
//  i_div_iter_srcB             in   XLEN  divisor
//  o_div_iter_ready            out  1     high in IDLE and DONE
//  o_div_iter_valid            out  1     one-cycle result strobe (DONE state)
//  o_div_iter_srcA_Dsign       out  1     srcA[XLEN-1] of accepted op
//  o_div_iter_srcB_Dsign       out  1     srcB[XLEN-1] (div-by-zero override below)
//  o_div_iter_srcA_Wsign       out  1     srcA[XLEN/2-1] of accepted op
//  o_div_iter_srcB_Wsign       out  1     srcB[XLEN/2-1] (div-by-zero override below)
//  o_div_iter_control          out  2     control of accepted op
//  o_div_iter_isword           out  1     isword of accepted op
//  o_div_iter_quotient         out  XLEN  quotient magnitude
//  o_div_iter_remainder        out  XLEN  remainder magnitude
// BEHAVIOUR
//  Reset: state IDLE; o_valid 0; o_ready 1; all flags, control, isword, quotient, remainder 0.
//  Operand prep at accept (N = XLEN, or XLEN/2 if isword):
//    - Operands are the low N bits; signed ops (control[0]=0) take |x| of N-bit two's complement.
//    - Unsigned ops use the value as-is. |MIN| = 2^(N-1) as unsigned N-bit.
//    - Sign flags always latch raw operand bits, independent of control.
//  FSM states: IDLE, BUSY, DONE.
//    - IDLE/DONE + start, N-bit divisor==0: go DONE.
//      quotient = all ones (XLEN bits); remainder = dividend magnitude.
//      Dsign_B := Dsign_A and Wsign_B := Wsign_A, so downstream XOR = 0 and REM restores dividend.
//    - IDLE/DONE + start, divisor!=0: go BUSY; load cnt = N-1, rem = 0, shift reg = dividend magnitude.
//    - BUSY: one step per cycle:
//        r' = {rem, next dividend MSB} (XLEN+1 bits);
//        if r' >= divisor then rem = r'-divisor, qbit 1; else rem = r', qbit 0;
//        qbit shifts into quotient LSB.
//      At cnt==0, take the final step and go DONE; otherwise decrement cnt.
//    - DONE: o_valid=1 for exactly one cycle, then IDLE unless a new start is accepted.
//  Latency: start sampled in cycle 0 -> o_valid in cycle N+1 (65 for XLEN=64, 33 for W).
//    Divide-by-zero: o_valid in cycle 1.
//  Result outputs update only on DONE entry and hold until the next DONE; upper XLEN-N bits are 0 for W.
//  Overflow (MIN/-1) needs no special case: magnitudes give q=2^(N-1), r=0.
//  Start while BUSY is ignored: ready is low, the request is not captured.
//  Flush: in BUSY or DONE, next state IDLE; o_valid forced 0 that cycle; results/flags not updated.
//    Flush takes priority over a same-cycle start.
//  Reset mid-op: as reset above; in-flight op discarded, no valid.
// TESTING
//  1. DIV A=-7 B=2 -> valid at cycle 65; q=3, r=1; Dsign A=1, B=0; ready high in cycle 65.
//  2. DIVU A=100 B=7 -> valid at cycle 65; q=14, r=2; all flags 0; control=01.
//  3. REM A=-5 B=0 -> valid at cycle 1; q=0xFFFF_FFFF_FFFF_FFFF, r=5; Dsign A=B=1, Wsign A=B=1.
//  4. DIVW A=0xFFFF_FFFF_8000_0000 B=0xFFFF_FFFF_FFFF_FFFF.
//     -> valid at cycle 33; q=0x0000_0000_8000_0000, r=0; Wsign A=B=1; isword=1.
//  5. Start DIVU 100/7; flush at cycle 10 -> IDLE at cycle 11, no valid ever.
//     Start DIVU 9/3 at cycle 11 -> valid at cycle 76, q=3, r=0.
//  6. Start at cycle 0; second start at cycle 5 (ignored); i_rst at cycle 20.
//     -> all outputs 0 at cycle 21, ready=1, no valid.

Source files
------------

// File: rtl/core_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : core_div_iter
// Description : Iterative radix-2 restoring divider producing unsigned
//               quotient/remainder magnitudes plus operand sign flags.
// Revision    : 1.0 - initial release
// ============================================================================
module core_div_iter #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_iter_start,
    input  logic            i_div_iter_flush,
    input  logic [1:0]      i_div_iter_control,
    input  logic            i_div_iter_isword,
    input  logic [XLEN-1:0] i_div_iter_srcA,
    input  logic [XLEN-1:0] i_div_iter_srcB,
    output logic            o_div_iter_ready,
    output logic            o_div_iter_valid,
    output logic            o_div_iter_srcA_Dsign,
    output logic            o_div_iter_srcB_Dsign,
    output logic            o_div_iter_srcA_Wsign,
    output logic            o_div_iter_srcB_Wsign,
    output logic [1:0]      o_div_iter_control,
    output logic            o_div_iter_isword,
    output logic [XLEN-1:0] o_div_iter_quotient,
    output logic [XLEN-1:0] o_div_iter_remainder
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [CW-1:0] c_CNT_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] c_CNT_WORD = CW'(HALF - 1);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_quo;
    logic            r_p_a_dsign, r_p_b_dsign, r_p_a_wsign, r_p_b_wsign;
    logic [1:0]      r_p_control;
    logic            r_p_isword;
    logic            r_a_dsign, r_b_dsign, r_a_wsign, r_b_wsign;
    logic [1:0]      r_control;
    logic            r_isword;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;

    logic            w_signed;
    logic [HALF-1:0] w_a_lo_neg, w_b_lo_neg;
    logic [XLEN-1:0] w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN-1:0] w_dvd_init;
    logic            w_b_zero;
    logic [CW-1:0]   w_cnt_init;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_signed   = ~i_div_iter_control[0];
    assign w_a_lo_neg = ~i_div_iter_srcA[HALF-1:0] + {{(HALF-1){1'b0}}, 1'b1};
    assign w_b_lo_neg = ~i_div_iter_srcB[HALF-1:0] + {{(HALF-1){1'b0}}, 1'b1};
    assign w_a_neg    = ~i_div_iter_srcA + {{(XLEN-1){1'b0}}, 1'b1};
    assign w_b_neg    = ~i_div_iter_srcB + {{(XLEN-1){1'b0}}, 1'b1};

    // Magnitude of the N-bit two's complement operand; 2^(N-1) falls out naturally for MIN.
    always_comb begin
        if (i_div_iter_isword) begin
            w_a_mag = (w_signed && i_div_iter_srcA[HALF-1]) ? {{HALF{1'b0}}, w_a_lo_neg}
                                                            : {{HALF{1'b0}}, i_div_iter_srcA[HALF-1:0]};
            w_b_mag = (w_signed && i_div_iter_srcB[HALF-1]) ? {{HALF{1'b0}}, w_b_lo_neg}
                                                            : {{HALF{1'b0}}, i_div_iter_srcB[HALF-1:0]};
            w_dvd_init = {w_a_mag[HALF-1:0], {HALF{1'b0}}};
            w_cnt_init = c_CNT_WORD;
        end else begin
            w_a_mag    = (w_signed && i_div_iter_srcA[XLEN-1]) ? w_a_neg : i_div_iter_srcA;
            w_b_mag    = (w_signed && i_div_iter_srcB[XLEN-1]) ? w_b_neg : i_div_iter_srcB;
            w_dvd_init = w_a_mag;
            w_cnt_init = c_CNT_FULL;
        end
    end

    assign w_b_zero = (w_b_mag == '0);

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    assign w_trial   = {r_rem, r_dvd[XLEN-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dvs});
    assign w_diff    = w_trial[XLEN-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_trial[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_p_a_dsign <= 1'b0;
            r_p_b_dsign <= 1'b0;
            r_p_a_wsign <= 1'b0;
            r_p_b_wsign <= 1'b0;
            r_p_control <= 2'b00;
            r_p_isword  <= 1'b0;
            r_a_dsign   <= 1'b0;
            r_b_dsign   <= 1'b0;
            r_a_wsign   <= 1'b0;
            r_b_wsign   <= 1'b0;
            r_control   <= 2'b00;
            r_isword    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                c_S_BUSY: begin
                    if (i_div_iter_flush) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                        r_quo <= w_quo_nxt;
                        if (r_cnt == '0) begin
                            r_state     <= c_S_DONE;
                            r_quotient  <= w_quo_nxt;
                            r_remainder <= w_rem_nxt;
                            r_a_dsign   <= r_p_a_dsign;
                            r_b_dsign   <= r_p_b_dsign;
                            r_a_wsign   <= r_p_a_wsign;
                            r_b_wsign   <= r_p_b_wsign;
                            r_control   <= r_p_control;
                            r_isword    <= r_p_isword;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_div_iter_flush || !i_div_iter_start) begin
                        r_state <= c_S_IDLE;
                    end else if (w_b_zero) begin
                        // Divisor sign mirrors dividend so downstream sign fix-up is a no-op.
                        r_state     <= c_S_DONE;
                        r_quotient  <= '1;
                        r_remainder <= w_a_mag;
                        r_a_dsign   <= i_div_iter_srcA[XLEN-1];
                        r_b_dsign   <= i_div_iter_srcA[XLEN-1];
                        r_a_wsign   <= i_div_iter_srcA[HALF-1];
                        r_b_wsign   <= i_div_iter_srcA[HALF-1];
                        r_control   <= i_div_iter_control;
                        r_isword    <= i_div_iter_isword;
                    end else begin
                        r_state     <= c_S_BUSY;
                        r_cnt       <= w_cnt_init;
                        r_rem       <= '0;
                        r_dvd       <= w_dvd_init;
                        r_dvs       <= w_b_mag;
                        r_quo       <= '0;
                        r_p_a_dsign <= i_div_iter_srcA[XLEN-1];
                        r_p_b_dsign <= i_div_iter_srcB[XLEN-1];
                        r_p_a_wsign <= i_div_iter_srcA[HALF-1];
                        r_p_b_wsign <= i_div_iter_srcB[HALF-1];
                        r_p_control <= i_div_iter_control;
                        r_p_isword  <= i_div_iter_isword;
                    end
                end
            endcase
        end
    end

    assign o_div_iter_ready      = (r_state != c_S_BUSY);
    assign o_div_iter_valid      = (r_state == c_S_DONE) & ~i_div_iter_flush;
    assign o_div_iter_srcA_Dsign = r_a_dsign;
    assign o_div_iter_srcB_Dsign = r_b_dsign;
    assign o_div_iter_srcA_Wsign = r_a_wsign;
    assign o_div_iter_srcB_Wsign = r_b_wsign;
    assign o_div_iter_control    = r_control;
    assign o_div_iter_isword     = r_isword;
    assign o_div_iter_quotient   = r_quotient;
    assign o_div_iter_remainder  = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_core_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_div_iter
// Description : Scoreboard bench for core_div_iter (XLEN = 64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_div_iter;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [3:0]  flags;
        logic [2:0]  ctl_isw;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  control;
    logic        isword;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        ready, valid;
    logic        a_dsign, b_dsign, a_wsign, b_wsign;
    logic [1:0]  o_control;
    logic        o_isword;
    logic [63:0] quotient, remainder;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_valid;

    core_div_iter #(.XLEN(64)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_div_iter_start      (start),
        .i_div_iter_flush      (flush),
        .i_div_iter_control    (control),
        .i_div_iter_isword     (isword),
        .i_div_iter_srcA       (src_a),
        .i_div_iter_srcB       (src_b),
        .o_div_iter_ready      (ready),
        .o_div_iter_valid      (valid),
        .o_div_iter_srcA_Dsign (a_dsign),
        .o_div_iter_srcB_Dsign (b_dsign),
        .o_div_iter_srcA_Wsign (a_wsign),
        .o_div_iter_srcB_Wsign (b_wsign),
        .o_div_iter_control    (o_control),
        .o_div_iter_isword     (o_isword),
        .o_div_iter_quotient   (quotient),
        .o_div_iter_remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: divide operand magnitudes with the simulator's own arithmetic.
    function automatic exp_t model(input logic [1:0] ctl, input logic isw,
                                   input logic [63:0] a, input logic [63:0] b, input int c0);
        exp_t        e;
        logic [63:0] ma, mb;
        logic [31:0] a32, b32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (isw) begin
            ma = (!ctl[0] && a32[31]) ? {32'd0, 32'd0 - a32} : {32'd0, a32};
            mb = (!ctl[0] && b32[31]) ? {32'd0, 32'd0 - b32} : {32'd0, b32};
        end else begin
            ma = (!ctl[0] && a[63]) ? 64'd0 - a : a;
            mb = (!ctl[0] && b[63]) ? 64'd0 - b : b;
        end
        e.ctl_isw = {ctl, isw};
        if (mb == 64'd0) begin
            e.q     = '1;
            e.r     = ma;
            e.flags = {a[63], a[63], a[31], a[31]};
            e.cyc   = c0 + 1;
        end else begin
            e.q     = ma / mb;
            e.r     = ma % mb;
            e.flags = {a[63], b[63], a[31], b[31]};
            e.cyc   = c0 + (isw ? 33 : 65);
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (cyc !== e.cyc) $display("FAIL latency: valid at cycle %0d, want %0d", cyc, e.cyc);
                    else n_pass++;
                    n_checks++;
                    if (quotient !== e.q) $display("FAIL quotient: got %h want %h", quotient, e.q);
                    else n_pass++;
                    n_checks++;
                    if (remainder !== e.r) $display("FAIL remainder: got %h want %h", remainder, e.r);
                    else n_pass++;
                    n_checks++;
                    if ({a_dsign, b_dsign, a_wsign, b_wsign} !== e.flags)
                        $display("FAIL sign_flags: got %b want %b", {a_dsign, b_dsign, a_wsign, b_wsign}, e.flags);
                    else n_pass++;
                    n_checks++;
                    if ({o_control, o_isword} !== e.ctl_isw)
                        $display("FAIL ctl_isword: got %b want %b", {o_control, o_isword}, e.ctl_isw);
                    else n_pass++;
                    n_checks++;
                    if (ready !== 1'b1) $display("FAIL ready_at_valid: got %b want 1", ready);
                    else n_pass++;
                end
            end
        end
    endtask

    // All driving tasks start and end just after a rising edge.
    task automatic issue(input logic [1:0] ctl, input logic isw,
                         input logic [63:0] a, input logic [63:0] b, input logic push);
        if (push) sb.push_back(model(ctl, isw, a, b, cyc));
        start   = 1'b1;
        control = ctl;
        isword  = isw;
        src_a   = a;
        src_b   = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (ready !== 1'b1) begin
            n_checks++;
            $display("FAIL ready_timeout: ready=%b want 1", ready);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL drain_timeout: %0d pending want 0", sb.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({ready, valid, a_dsign, b_dsign, a_wsign, b_wsign, o_control, o_isword} !== 9'b1_0000_0000)
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {ready, valid, a_dsign, b_dsign, a_wsign, b_wsign, o_control, o_isword});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 128'd0)
            $display("FAIL reset_data: got %h %h want 0 0", quotient, remainder);
        else n_pass++;
    endtask

    task automatic test_directed();
        wait_ready(); issue(2'b00, 1'b0, -64'sd7, 64'd2, 1'b1);
        wait_drain();
        wait_ready(); issue(2'b01, 1'b0, 64'd100, 64'd7, 1'b1);
        wait_drain();
        wait_ready(); issue(2'b10, 1'b0, -64'sd5, 64'd0, 1'b1);
        wait_drain();
        wait_ready(); issue(2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_drain();
        // Signed full-width overflow and W divide-by-zero with nonzero upper divisor bits
        wait_ready(); issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        wait_drain();
        wait_ready(); issue(2'b11, 1'b1, 64'h0000_0000_8000_0009, 64'h1234_0000_0000_0000, 1'b1);
        wait_drain();
    endtask

    task automatic test_flush();
        int c0, v0;
        wait_ready();
        c0 = cyc;
        v0 = n_valid;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (cyc !== c0 + 11 || ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL flush_idle: cyc=%0d ready=%b valid=%b want cyc %0d ready 1 valid 0",
                     cyc, ready, valid, c0 + 11);
        else n_pass++;
        issue(2'b01, 1'b0, 64'd9, 64'd3, 1'b1);
        wait_drain();
        n_checks++;
        if (n_valid !== v0 + 1) $display("FAIL flush_valids: got %0d want %0d", n_valid - v0, 1);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int v0;
        wait_ready();
        issue(2'b00, 1'b0, 64'd1000, 64'd3, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", ready);
        else n_pass++;
        issue(2'b01, 1'b0, 64'd50, 64'd5, 1'b0);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        v0 = n_valid;
        n_checks++;
        if ({ready, valid, a_dsign, b_dsign, a_wsign, b_wsign, o_control, o_isword} !== 9'b1_0000_0000
            || quotient !== 64'd0 || remainder !== 64'd0)
            $display("FAIL midop_reset: ctl=%b q=%h r=%h want 100000000 0 0",
                     {ready, valid, a_dsign, b_dsign, a_wsign, b_wsign, o_control, o_isword},
                     quotient, remainder);
        else n_pass++;
        repeat (80) begin @(posedge clk); #1; end
        n_checks++;
        if (n_valid !== v0) $display("FAIL midop_valids: got %0d want 0", n_valid - v0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        logic [1:0]  ctl;
        logic        isw;
        int          k;
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            ctl = 2'($urandom_range(0, 3));
            isw = 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = {$urandom, $urandom};
                2:       b = 64'($urandom_range(1, 20));
                default: b = {$urandom, 32'd0} | 64'($urandom_range(0, 1));
            endcase
            issue(ctl, isw, a, b, 1'b1);
            // Next request lands in the DONE cycle of this one.
            k = 0;
            while (valid !== 1'b1 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            if (valid !== 1'b1) begin
                n_checks++;
                $display("FAIL b2b_timeout: valid=%b want 1", valid);
            end
        end
        wait_drain();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_valid  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        control  = 2'b00;
        isword   = 1'b0;
        src_a    = '0;
        src_b    = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_directed();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
